// File: rtl/fifo_unpack_reader.sv
// fifo_unpack_reader
// Drains IN_WIDTH-bit words from an upstream first-word-fall-through FIFO and
// presents them downstream as a FWFT stream of OUT_WIDTH-bit parts. Each part
// is handed over in one cycle, with no bubble between consecutive words.
//
// Build option:
//   UNPACK_MSB_FIRST_EN - when defined, the most significant part of each word
//                         is emitted first. The default emits the least
//                         significant part first. Handshake, last and timing
//                         are the same in both builds.
//
// IN_WIDTH must be an integer multiple (>= 2) of OUT_WIDTH.

module fifo_unpack_reader #(
   parameter int IN_WIDTH  = 64,
   parameter int OUT_WIDTH = 16
) (
   input  logic                 CLK,
   input  logic                 RST_N,
   input  logic [IN_WIDTH-1:0]  fifo_dout,
   input  logic                 fifo_empty,
   output logic                 fifo_rd_en,
   output logic [OUT_WIDTH-1:0] dout,
   output logic                 last,
   output logic                 empty,
   input  logic                 rd_en
);

   localparam int RATIO = IN_WIDTH / OUT_WIDTH;
   localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(RATIO - 1);

   // Held word, index of the part on dout, and the no-part flag.
   logic [IN_WIDTH-1:0]  r_buf;
   logic [CNT_W-1:0]     r_cnt;
   logic                 r_empty;
   logic [OUT_WIDTH-1:0] r_dout;
   logic                 r_last;

   logic                 w_take;
   logic                 w_at_end;
   logic                 w_load;
   logic [IN_WIDTH-1:0]  w_buf_nxt;
   logic [CNT_W-1:0]     w_cnt_nxt;
   logic                 w_empty_nxt;
   logic [CNT_W-1:0]     w_sel_nxt;
   logic [OUT_WIDTH-1:0] w_dout_nxt;
   logic                 w_last_nxt;
   logic [OUT_WIDTH-1:0] w_parts [RATIO];

   assign w_take   = ~r_empty & rd_en;
   assign w_at_end = (r_cnt == LAST_IDX);

   // Load whenever nothing is held, or the final part of the held word is
   // being taken in this cycle; the latter keeps the stream bubble-free.
   assign w_load = ~fifo_empty & (r_empty | (w_take & w_at_end));

   // RST_N gates only the outgoing pop so the upstream FIFO is never popped
   // while the block is held in reset. The internal load path does not need
   // it because every register is forced by the asynchronous reset anyway.
   assign fifo_rd_en = RST_N & w_load;

   // Next-state of the held word, part counter and empty flag.
   always_comb begin
      w_buf_nxt   = r_buf;
      w_cnt_nxt   = r_cnt;
      w_empty_nxt = r_empty;
      if (w_load) begin
         w_buf_nxt   = fifo_dout;
         w_cnt_nxt   = '0;
         w_empty_nxt = 1'b0;
      end else if (w_take && !w_at_end) begin
         w_cnt_nxt = r_cnt + 1'b1;
      end else if (w_take && w_at_end) begin
         // Last part taken and nothing upstream: buf and cnt are left as is.
         w_empty_nxt = 1'b1;
      end
   end

   // Slice the next word into parts; part 0 is the least significant.
   for (genvar g = 0; g < RATIO; g++) begin : g_part
      assign w_parts[g] = w_buf_nxt[g*OUT_WIDTH +: OUT_WIDTH];
   end

`ifdef UNPACK_MSB_FIRST_EN
   assign w_sel_nxt = LAST_IDX - w_cnt_nxt;
`else
   assign w_sel_nxt = w_cnt_nxt;
`endif

   assign w_dout_nxt = w_parts[w_sel_nxt];
   assign w_last_nxt = ~w_empty_nxt & (w_cnt_nxt == LAST_IDX);

   // State and output registers; dout/last are precomputed from next-state so
   // that there is no combinational path from fifo_dout to dout.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_buf   <= '0;
         r_cnt   <= '0;
         r_empty <= 1'b1;
         r_dout  <= '0;
         r_last  <= 1'b0;
      end else begin
         r_buf   <= w_buf_nxt;
         r_cnt   <= w_cnt_nxt;
         r_empty <= w_empty_nxt;
         r_dout  <= w_dout_nxt;
         r_last  <= w_last_nxt;
      end
   end

   assign dout  = r_dout;
   assign last  = r_last;
   assign empty = r_empty;

endmodule

// File: tb/tb_fifo_unpack_reader.sv
// Self-checking bench for fifo_unpack_reader (IN_WIDTH=64, OUT_WIDTH=16).
// An upstream FWFT FIFO is modelled with a queue; every word pushed also
// pushes its expected parts onto a scoreboard popped on each take.

module tb_fifo_unpack_reader;

   localparam int IW = 64;
   localparam int OW = 16;
   localparam int R  = IW / OW;

   logic          CLK = 1'b0;
   logic          RST_N = 1'b0;
   logic [IW-1:0] fifo_dout = '0;
   logic          fifo_empty = 1'b1;
   logic          fifo_rd_en;
   logic [OW-1:0] dout;
   logic          last;
   logic          empty;
   logic          rd_en = 1'b0;

   fifo_unpack_reader #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) dut (
      .CLK        (CLK),
      .RST_N      (RST_N),
      .fifo_dout  (fifo_dout),
      .fifo_empty (fifo_empty),
      .fifo_rd_en (fifo_rd_en),
      .dout       (dout),
      .last       (last),
      .empty      (empty),
      .rd_en      (rd_en)
   );

   always #5 CLK = ~CLK;

   logic [IW-1:0] up_q [$];
   logic [OW-1:0] exp_dout_q [$];
   logic          exp_last_q [$];

   int n_pass  = 0;
   int n_total = 0;

   logic [OW-1:0] s_dout;
   logic          s_last;
   logic          s_empty;
   logic          s_pop;

   task automatic push_word(input logic [IW-1:0] w);
      logic [IW-1:0] sh;
      int idx;
      up_q.push_back(w);
      for (int i = 0; i < R; i++) begin
`ifdef UNPACK_MSB_FIRST_EN
         idx = R - 1 - i;
`else
         idx = i;
`endif
         sh = w >> (idx * OW);
         exp_dout_q.push_back(sh[OW-1:0]);
         exp_last_q.push_back(i == R - 1);
      end
   endtask

   // One clock cycle: drive inputs, sample everything before the edge,
   // then let the upstream model honour the pop seen at that edge.
   task automatic tick(input logic rd);
      rd_en      = rd;
      fifo_empty = (up_q.size() == 0);
      fifo_dout  = fifo_empty ? '0 : up_q[0];
      #1;
      s_dout  = dout;
      s_last  = last;
      s_empty = empty;
      s_pop   = fifo_rd_en;
      @(posedge CLK);
      #1;
      if (s_pop && up_q.size() > 0) void'(up_q.pop_front());
      @(negedge CLK);
   endtask

   task automatic test_reset();
      rd_en = 1'b1;
      @(negedge CLK);
      #1;
      n_total++;
      if (empty !== 1'b1 || dout !== '0 || last !== 1'b0 || fifo_rd_en !== 1'b0)
         $display("FAIL reset_state: empty=%b dout=%h last=%b rd=%b, want 1 0000 0 0",
                  empty, dout, last, fifo_rd_en);
      else n_pass++;
      @(negedge CLK);
      RST_N = 1'b1;
      tick(1'b1);
      tick(1'b1);
      n_total++;
      if (s_empty !== 1'b1 || s_pop !== 1'b0 || s_last !== 1'b0)
         $display("FAIL reset_release_idle: empty=%b pop=%b last=%b, want 1 0 0",
                  s_empty, s_pop, s_last);
      else n_pass++;
   endtask

   task automatic test_single_word();
      int pops = 0, takes = 0, first_pop = -1, first_take = -1, last_take = -1;
      logic [OW-1:0] ed;
      logic el;
      push_word(64'h0011_2233_4455_6677);
      for (int c = 0; c < 20 && takes < R; c++) begin
         tick(1'b1);
         if (s_pop) begin pops++; if (first_pop < 0) first_pop = c; end
         if (!s_empty) begin
            takes++;
            if (first_take < 0) first_take = c;
            last_take = c;
            n_total++;
            if (exp_dout_q.size() == 0)
               $display("FAIL single_part: unexpected part %h", s_dout);
            else begin
               ed = exp_dout_q.pop_front();
               el = exp_last_q.pop_front();
               if (s_dout !== ed || s_last !== el)
                  $display("FAIL single_part: dout=%h last=%b, want %h %b", s_dout, s_last, ed, el);
               else n_pass++;
            end
         end
      end
      n_total++;
      if (takes !== R) $display("FAIL single_takes: got %0d, want %0d", takes, R);
      else n_pass++;
      n_total++;
      if (first_pop !== 0 || first_take !== 1)
         $display("FAIL single_latency: pop@%0d take@%0d, want 0 1", first_pop, first_take);
      else n_pass++;
      n_total++;
      if (last_take - first_take !== R - 1)
         $display("FAIL single_consecutive: span %0d, want %0d", last_take - first_take, R - 1);
      else n_pass++;
      tick(1'b1);
      n_total++;
      if (pops !== 1 || s_pop !== 1'b0 || s_empty !== 1'b1 || s_last !== 1'b0)
         $display("FAIL single_end: pops=%0d pop=%b empty=%b last=%b, want 1 0 1 0",
                  pops, s_pop, s_empty, s_last);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      int pop_c [$];
      int takes = 0, first_take = -1, last_take = -1;
      logic [OW-1:0] ed;
      logic el;
      push_word(64'hA1A2_B3B4_C5C6_D7D8);
      push_word(64'h1357_9BDF_2468_ACE0);
      push_word(64'hFFFF_0000_8001_7FFE);
      for (int c = 0; c < 60 && takes < 3 * R; c++) begin
         tick(1'b1);
         if (s_pop) pop_c.push_back(c);
         if (!s_empty) begin
            takes++;
            if (first_take < 0) first_take = c;
            last_take = c;
            n_total++;
            if (exp_dout_q.size() == 0)
               $display("FAIL b2b_part: unexpected part %h", s_dout);
            else begin
               ed = exp_dout_q.pop_front();
               el = exp_last_q.pop_front();
               if (s_dout !== ed || s_last !== el)
                  $display("FAIL b2b_part: dout=%h last=%b, want %h %b", s_dout, s_last, ed, el);
               else n_pass++;
            end
         end
      end
      n_total++;
      if (takes !== 3 * R || last_take - first_take !== 3 * R - 1)
         $display("FAIL b2b_stream: takes=%0d span=%0d, want %0d %0d",
                  takes, last_take - first_take, 3 * R, 3 * R - 1);
      else n_pass++;
      n_total++;
      if (pop_c.size() !== 3)
         $display("FAIL b2b_pops: got %0d pops, want 3", pop_c.size());
      else if (pop_c[1] - pop_c[0] !== R || pop_c[2] - pop_c[0] !== 2 * R)
         $display("FAIL b2b_pops: offsets %0d %0d, want %0d %0d",
                  pop_c[1] - pop_c[0], pop_c[2] - pop_c[0], R, 2 * R);
      else n_pass++;
      tick(1'b1);
      n_total++;
      if (s_empty !== 1'b1) $display("FAIL b2b_end_empty: empty=%b, want 1", s_empty);
      else n_pass++;
   endtask

   task automatic test_toggle();
      int pop_c [$];
      int take_c [$];
      int unstable = 0;
      logic hold_prev = 1'b0;
      logic [OW-1:0] prev_dout = '0;
      logic rd;
      logic [OW-1:0] ed;
      logic el;
      push_word(64'h0123_4567_89AB_CDEF);
      push_word(64'hDEAD_BEEF_CAFE_F00D);
      for (int c = 0; c < 80 && take_c.size() < 2 * R; c++) begin
         rd = ((c % 4) == 0) || ((c % 4) == 3);
         tick(rd);
         if (s_pop) pop_c.push_back(c);
         if (hold_prev && !s_empty && s_dout !== prev_dout) unstable++;
         hold_prev = !s_empty && !rd;
         prev_dout = s_dout;
         if (!s_empty && rd) begin
            take_c.push_back(c);
            n_total++;
            if (exp_dout_q.size() == 0)
               $display("FAIL toggle_part: unexpected part %h", s_dout);
            else begin
               ed = exp_dout_q.pop_front();
               el = exp_last_q.pop_front();
               if (s_dout !== ed || s_last !== el)
                  $display("FAIL toggle_part: dout=%h last=%b, want %h %b", s_dout, s_last, ed, el);
               else n_pass++;
            end
         end
      end
      n_total++;
      if (unstable !== 0) $display("FAIL toggle_stable: %0d changes while held, want 0", unstable);
      else n_pass++;
      n_total++;
      if (pop_c.size() !== 2 || take_c.size() < R)
         $display("FAIL toggle_pop: pops=%0d takes=%0d, want 2 >=%0d", pop_c.size(), take_c.size(), R);
      else if (pop_c[1] !== take_c[R-1])
         $display("FAIL toggle_pop: second pop@%0d, want @%0d", pop_c[1], take_c[R-1]);
      else n_pass++;
      tick(1'b0);
   endtask

   task automatic test_idle();
      int bad = 0;
      logic [OW-1:0] d0;
      tick(1'b1);
      d0 = s_dout;
      for (int c = 0; c < 10; c++) begin
         tick(1'b1);
         if (s_pop !== 1'b0 || s_empty !== 1'b1 || s_last !== 1'b0 || s_dout !== d0) bad++;
      end
      n_total++;
      if (bad !== 0) $display("FAIL idle: %0d cycles changed state or popped, want 0", bad);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      int takes = 0, pops = 0, bad = 0;
      logic [OW-1:0] ed;
      logic el;
      push_word(64'h1111_2222_3333_4444);
      push_word(64'h5555_6666_7777_8888);
      for (int c = 0; c < 20 && takes < 2; c++) begin
         tick(1'b1);
         if (!s_empty) begin
            takes++;
            void'(exp_dout_q.pop_front());
            void'(exp_last_q.pop_front());
         end
      end
      RST_N = 1'b0;
      #1;
      n_total++;
      if (empty !== 1'b1 || dout !== '0 || last !== 1'b0)
         $display("FAIL rstmid_async: empty=%b dout=%h last=%b, want 1 0000 0", empty, dout, last);
      else n_pass++;
      for (int i = 0; i < R - 2; i++) begin
         void'(exp_dout_q.pop_front());
         void'(exp_last_q.pop_front());
      end
      for (int c = 0; c < 3; c++) begin
         tick(1'b1);
         if (s_pop !== 1'b0 || s_empty !== 1'b1) bad++;
      end
      n_total++;
      if (bad !== 0) $display("FAIL rstmid_no_pop: %0d cycles popped in reset, want 0", bad);
      else n_pass++;
      RST_N = 1'b1;
      takes = 0;
      for (int c = 0; c < 20 && takes < R; c++) begin
         tick(1'b1);
         if (s_pop) pops++;
         if (!s_empty) begin
            takes++;
            n_total++;
            if (exp_dout_q.size() == 0)
               $display("FAIL rstmid_part: unexpected part %h", s_dout);
            else begin
               ed = exp_dout_q.pop_front();
               el = exp_last_q.pop_front();
               if (s_dout !== ed || s_last !== el)
                  $display("FAIL rstmid_part: dout=%h last=%b, want %h %b", s_dout, s_last, ed, el);
               else n_pass++;
            end
         end
      end
      tick(1'b1);
      n_total++;
      if (pops !== 1 || takes !== R || s_empty !== 1'b1)
         $display("FAIL rstmid_after: pops=%0d takes=%0d empty=%b, want 1 %0d 1", pops, takes, s_empty, R);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_single_word();
      test_back_to_back();
      test_toggle();
      test_idle();
      test_reset_mid();
      n_total++;
      if (exp_dout_q.size() !== 0)
         $display("FAIL scoreboard_drained: %0d parts left, want 0", exp_dout_q.size());
      else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish, %0d/%0d passed", n_pass, n_total);
      $fatal(1);
   end

endmodule

// File: doc/fifo_unpack_reader.md
# fifo_unpack_reader

Read side of the design's first-word-fall-through (FWFT) synchronous FIFOs. It drains IN_WIDTH-bit words from an upstream FWFT FIFO and presents them to a downstream consumer as a stream of OUT_WIDTH-bit parts. The downstream interface is itself FWFT (dout/empty/rd_en), so the block can stand anywhere a narrow FIFO output is expected, for example on the path from wide hash results to the narrow host output bus. Throughput is one part per cycle with no bubbles between consecutive words.

## Interface
- IN_WIDTH, default 64: upstream word width. Must equal RATIO × OUT_WIDTH.
- OUT_WIDTH, default 16: downstream part width.
- RATIO (derived): IN_WIDTH / OUT_WIDTH. Must be an integer of at least 2. Counter width is clog2(RATIO).

Ports:
- CLK  in  1: the only clock. All state changes on its rising edge.
- RST_N  in  1: reset, asynchronous and active-low.
- fifo_dout  in  IN_WIDTH: head word of the upstream FWFT FIFO.
- fifo_empty  in  1: upstream FIFO has no word.
- fifo_rd_en  out  1: pops the upstream FIFO. Combinational.
- dout  out  OUT_WIDTH: current part. Registered.
- last  out  1: the current part is the final part of its word. Registered.
- empty  out  1: no part is available. Registered.
- rd_en  in  1: downstream consumes the current part.

## Operation
- State:
  - word register buf[IN_WIDTH-1:0]
  - part counter cnt, range 0..RATIO-1
  - flag empty
- Definitions:
  - take = ~empty & rd_en
  - at_end = (cnt == RATIO-1)
- Pop rule: fifo_rd_en = RST_N & ~fifo_empty & (empty | (take & at_end)).
- On fifo_rd_en:
  - buf <= fifo_dout
  - cnt <= 0
  - empty <= 0
- On take & ~at_end: cnt <= cnt+1.
- On take & at_end & fifo_empty: empty <= 1. cnt and buf are don't-care after this.
- Output selection: dout = buf[cnt*OUT_WIDTH +: OUT_WIDTH], so part 0 is the least significant. Outputs come from registered state; there is no combinational path from fifo_dout to dout.
- last = ~empty & at_end.
- rd_en while empty is ignored; it causes no state change.
- When take & at_end & ~fifo_empty occur together, the next word is loaded in the same cycle. No empty cycle is inserted.
- Any fifo_empty change while the block holds a word with cnt < RATIO-1 has no effect until the end of that word.
- Reset (RST_N low):
  - empty=1, cnt=0, buf=0, hence dout=0 and last=0
  - fifo_rd_en=0
  - A partially consumed word is discarded. The upstream FIFO is not popped again for it.

## Timing
- Load latency: if fifo_empty is low in cycle n while the block is empty, fifo_rd_en is high in cycle n and empty is low in cycle n+1, with part 0 on dout.
- Each part stays on dout until the cycle in which take is high. Advance takes effect at the next edge.
- A word occupies the output for exactly RATIO take-cycles.
- Sustained rate: with rd_en held high and the FIFO never empty, one part per cycle and one pop every RATIO cycles.
- After reset deassertion, the first fifo_rd_en occurs no earlier than the first cycle with RST_N high.

## Configuration
- UNPACK_MSB_FIRST_EN:
  - Defined: part order is reversed, dout = buf[(RATIO-1-cnt)*OUT_WIDTH +: OUT_WIDTH], so the most significant part is emitted first.
  - Undefined (default): least significant part first.
- All handshake, last and timing behaviour is identical in both builds.

## Test plan
- Reset, then upstream holds 0x0011_2233_4455_6677 (IN=64, OUT=16) with rd_en=1 continuously:
  - dout sequence is 0x6677, 0x4455, 0x2233, 0x0011 on consecutive cycles
  - last is high only on 0x0011
  - fifo_rd_en pulses once
  - empty rises after the 4th part
- Same stimulus built with UNPACK_MSB_FIRST_EN: dout sequence is 0x0011, 0x2233, 0x4455, 0x6677; last is high on 0x6677.
- Three words queued upstream, rd_en=1: 12 consecutive valid parts with no empty cycle; fifo_rd_en is high on cycles 0, 4 and 8 relative to the first pop.
- rd_en toggled 1,0,0,1,… during one word: cnt advances only on take cycles, dout is stable while rd_en=0, and there is no pop until the 4th take.
- rd_en=1 while empty and fifo_empty=1 for 10 cycles: no state change, fifo_rd_en stays 0, empty stays 1.
- RST_N pulsed low after part 1 of a word:
  - empty=1, dout=0, last=0 immediately (asynchronous)
  - after release, the next upstream word is loaded starting at part 0, with no extra pop for the discarded word
